// File: rtl/posit_pkg.sv
// Shared constants and state type for the posit32 (es=3) encode/decode datapath.
package posit_pkg;

    localparam int unsigned NBITS = 32;
    localparam int unsigned ES    = 3;

    localparam logic [NBITS-1:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [NBITS-1:0] MINPOS = 32'h0000_0001;
    localparam logic [NBITS-1:0] NAR    = 32'h8000_0000;

    localparam logic signed [5:0] K_SAT_HI = 6'sd30;
    localparam logic signed [5:0] K_SAT_LO = -6'sd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REGIME   = 2'd1,
        PACK     = 2'd2,
        COMPLETE = 2'd3
    } enc_state_t;

endpackage

// File: rtl/posit_regime_gen.sv
// Regime run-length generator: MSB-aligned regime bit pattern and its length for a given k.
module posit_regime_gen
    import posit_pkg::*;
(
    input  logic [5:0]       k,
    output logic [NBITS-1:0] pattern,
    output logic [5:0]       rl
);

    logic [6:0] shamt;
    logic [5:0] mag;

    always_comb begin
        shamt   = 7'd0;
        mag     = 6'd0;
        pattern = '0;
        rl      = 6'd0;
        if (!k[5]) begin
            // k+1 leading ones; the terminating zero is implicit in the cleared tail
            shamt   = {1'b0, k} + 7'd1;
            pattern = ~({NBITS{1'b1}} >> shamt);
            rl      = k + 6'd2;
        end else begin
            // |k| leading zeros then a single one; k=-32 shifts the one out entirely
            mag     = 6'd0 - k;
            pattern = {1'b1, {(NBITS-1){1'b0}}} >> mag;
            rl      = mag + 6'd1;
        end
    end

endmodule

// File: rtl/posit_encode.sv
// Posit32 (es=3) packing stage: regime/exponent/fraction assembly, saturation and sign negation.
// Optional POSIT_ENC_SPECIAL_EN adds zero_in/nar_in special-value overrides.
module posit_encode
    import posit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      mantissa_in,
    input  logic [5:0]       k_in,
    input  logic             sign_in,
    input  logic [2:0]       exp_in,
`ifdef POSIT_ENC_SPECIAL_EN
    input  logic             zero_in,
    input  logic             nar_in,
`endif
    output logic [NBITS-1:0] posit_out,
    output logic             busy,
    output logic             done
);

    enc_state_t       state;
    logic [31:0]      mant_q;
    logic [5:0]       k_q;
    logic             sign_q;
    logic [2:0]       exp_q;
    logic [5:0]       rl_q;
    logic [NBITS-1:0] regime_q;
    logic             sat_hi_q;
    logic             sat_lo_q;
    logic [30:0]      body_q;
`ifdef POSIT_ENC_SPECIAL_EN
    logic             zero_q;
    logic             nar_q;
`endif

    logic [NBITS-1:0] pattern_w;
    logic [5:0]       rl_w;
    logic [63:0]      packed_w;
    logic [30:0]      body_w;

    posit_regime_gen u_regime_gen (
        .k       (k_q),
        .pattern (pattern_w),
        .rl      (rl_w)
    );

    // Exponent and fraction slide in right behind the rl regime bits; body is the top 31 bits.
    assign packed_w = {regime_q, 32'd0} | ({exp_q, mant_q, 29'd0} >> rl_q);
    assign body_w   = 31'(packed_w >> 33);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mant_q    <= '0;
            k_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rl_q      <= '0;
            regime_q  <= '0;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
            body_q    <= '0;
            posit_out <= '0;
            done      <= 1'b0;
`ifdef POSIT_ENC_SPECIAL_EN
            zero_q    <= 1'b0;
            nar_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mant_q <= mantissa_in;
                        k_q    <= k_in;
                        sign_q <= sign_in;
                        exp_q  <= exp_in;
`ifdef POSIT_ENC_SPECIAL_EN
                        zero_q <= zero_in;
                        nar_q  <= nar_in;
`endif
                        state  <= REGIME;
                    end
                end
                REGIME: begin
                    rl_q     <= rl_w;
                    regime_q <= pattern_w;
                    sat_hi_q <= ($signed(k_q) >= K_SAT_HI);
                    sat_lo_q <= ($signed(k_q) <= K_SAT_LO);
                    state    <= PACK;
                end
                PACK: begin
                    if (sat_hi_q) begin
                        body_q <= MAXPOS[30:0];
                    end else if (sat_lo_q) begin
                        body_q <= MINPOS[30:0];
                    end else begin
                        body_q <= body_w;
                    end
                    state <= COMPLETE;
                end
                COMPLETE: begin
`ifdef POSIT_ENC_SPECIAL_EN
                    if (nar_q) begin
                        posit_out <= NAR;
                    end else if (zero_q) begin
                        posit_out <= '0;
                    end else begin
                        posit_out <= sign_q ? (~{1'b0, body_q} + 32'd1) : {1'b0, body_q};
                    end
`else
                    posit_out <= sign_q ? (~{1'b0, body_q} + 32'd1) : {1'b0, body_q};
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
